// File: rtl/ps2_multi_pkg.sv
// rtl/ps2_multi_pkg.sv - shared register map, status bit indices and receiver state type
package ps2_multi_pkg;

    localparam logic [3:0]  OFF_DATA      = 4'h0;
    localparam logic [3:0]  OFF_STATUS    = 4'h4;
    localparam logic [3:0]  OFF_CTRL      = 4'h8;
    localparam logic [31:0] CH_STRIDE     = 32'h10;
    localparam logic [31:0] ADDR_IRQ_FLAG = 32'h100;

    localparam int ST_OVF  = 16;
    localparam int ST_FERR = 17;
    localparam int ST_TOUT = 18;

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_multi_controller_if.sv
// rtl/ps2_multi_controller_if.sv - device bus and interrupt signals of the PS/2 controller
interface ps2_multi_controller_if;
    logic        iDEV_REQ;
    logic        oDEV_BUSY;
    logic        iDEV_RW;
    logic [31:0] iDEV_ADDR;
    logic [31:0] iDEV_DATA;
    logic        oDEV_REQ;
    logic        iDEV_BUSY;
    logic [31:0] oDEV_DATA;
    logic        oDEV_IRQ_REQ;
    logic        iDEV_IRQ_BUSY;
    logic        iDEV_IRQ_ACK;

    modport master (
        output iDEV_REQ, iDEV_RW, iDEV_ADDR, iDEV_DATA, iDEV_BUSY, iDEV_IRQ_BUSY, iDEV_IRQ_ACK,
        input  oDEV_BUSY, oDEV_REQ, oDEV_DATA, oDEV_IRQ_REQ
    );

    modport slave (
        input  iDEV_REQ, iDEV_RW, iDEV_ADDR, iDEV_DATA, iDEV_BUSY, iDEV_IRQ_BUSY, iDEV_IRQ_ACK,
        output oDEV_BUSY, oDEV_REQ, oDEV_DATA, oDEV_IRQ_REQ
    );
endinterface

// File: rtl/ps2_multi_rx_channel.sv
// rtl/ps2_multi_rx_channel.sv - one PS/2 receiver with sync, edge detect, timeout and FIFO
// Parity checking is enabled by defining PS2_MULTI_PARITY_CHECK_EN.
module ps2_multi_rx_channel
    import ps2_multi_pkg::*;
#(
    parameter int P_FIFO_DEPTH   = 32,
    parameter int P_FIFO_DEPTH_N = 5,
    parameter int P_TIMEOUT      = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ps2_clk,
    input  logic                    i_ps2_data,
    input  logic                    i_rx_en,
    input  logic                    i_pop,
    output logic                    o_push,
    output logic                    o_overflow,
    output logic                    o_frame_err,
    output logic                    o_timeout,
    output logic [P_FIFO_DEPTH_N:0] o_count,
    output logic [7:0]              o_head
);

`ifdef PS2_MULTI_PARITY_CHECK_EN
    localparam bit C_PARITY_CHECK = 1'b1;
`else
    localparam bit C_PARITY_CHECK = 1'b0;
`endif
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [P_FIFO_DEPTH_N:0] C_FULL = (P_FIFO_DEPTH_N + 1)'(P_FIFO_DEPTH);

    logic [2:0]                r_clk_sync;
    logic [1:0]                r_dat_sync;
    logic                      r_fall;
    logic                      r_bit;
    rx_state_t                 r_state;
    logic [2:0]                r_bitcnt;
    logic [7:0]                r_shift;
    logic                      r_parity;
    logic [TW-1:0]             r_to_cnt;
    logic [7:0]                r_mem [P_FIFO_DEPTH];
    logic [P_FIFO_DEPTH_N-1:0] r_wptr;
    logic [P_FIFO_DEPTH_N-1:0] r_rptr;
    logic [P_FIFO_DEPTH_N:0]   r_count;

    logic w_stop_evt;
    logic w_to_evt;
    logic w_frame_ok;
    logic w_full;
    logic w_pop_ok;

    // Two sync flops, a third as history, then a registered falling-edge strobe
    // with the data bit delayed to line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_fall     <= 1'b0;
            r_bit      <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_fall     <= r_clk_sync[2] & ~r_clk_sync[1];
            r_bit      <= r_dat_sync[1];
        end
    end

    assign w_stop_evt = r_fall && (r_state == RX_STOP);
    assign w_to_evt   = (r_state != RX_IDLE) && !r_fall && (r_to_cnt == TW'(P_TIMEOUT - 1));
    assign w_frame_ok = r_bit && (!C_PARITY_CHECK || (^{r_shift, r_parity}));
    assign w_full     = (r_count == C_FULL);
    assign w_pop_ok   = i_pop && (r_count != '0);

    assign o_push      = w_stop_evt && w_frame_ok && i_rx_en && (!w_full || w_pop_ok);
    assign o_overflow  = w_stop_evt && w_frame_ok && i_rx_en && w_full && !w_pop_ok;
    assign o_frame_err = w_stop_evt && !w_frame_ok && i_rx_en;
    assign o_timeout   = w_to_evt && i_rx_en;
    assign o_count     = r_count;
    assign o_head      = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == RX_IDLE || r_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_evt) begin
                r_state <= RX_IDLE;
            end else if (r_fall) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!r_bit) begin
                            r_state  <= RX_SHIFT;
                            r_bitcnt <= '0;
                        end
                    end
                    RX_SHIFT: begin
                        r_shift  <= {r_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'(FRAME_BITS - 4)) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_parity <= r_bit;
                        r_state  <= RX_STOP;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (o_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({o_push, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_multi_controller.sv
// rtl/ps2_multi_controller.sv - multi-channel PS/2 receiver with bus registers and shared IRQ
// Parity checking in the channels is enabled by defining PS2_MULTI_PARITY_CHECK_EN.
module ps2_multi_controller
    import ps2_multi_pkg::*;
#(
    parameter int P_CHANNELS     = 2,
    parameter int P_FIFO_DEPTH   = 32,
    parameter int P_FIFO_DEPTH_N = 5,
    parameter int P_TIMEOUT      = 50000
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET_SYNC,
    ps2_multi_controller_if.slave bus,
    input  logic [P_CHANNELS-1:0] iPS2_CLOCK,
    input  logic [P_CHANNELS-1:0] iPS2_DATA
);

    logic [P_CHANNELS-1:0]   w_sel, w_pop, w_push, w_ovf_set, w_ferr_set, w_tout_set;
    logic [P_CHANNELS-1:0]   w_clr_ovf, w_clr_ferr, w_clr_tout, w_ctrl_wr, w_pend_set;
    logic [P_FIFO_DEPTH_N:0] w_count [P_CHANNELS];
    logic [7:0]              w_head  [P_CHANNELS];
    logic [P_CHANNELS-1:0]   r_rx_en, r_irq_en, r_ovf, r_ferr, r_tout, r_pending;
    logic                    r_req;
    logic [31:0]             r_data;
    logic [31:0]             w_rd_data;
    logic                    w_rd, w_wr, w_ch_hit, w_irq_hit;
    logic [1:0]              w_ch_idx;
    logic [3:0]              w_off;

    assign w_rd      = bus.iDEV_REQ && !bus.iDEV_RW;
    assign w_wr      = bus.iDEV_REQ && bus.iDEV_RW;
    assign w_ch_hit  = bus.iDEV_ADDR < (32'(P_CHANNELS) * CH_STRIDE);
    assign w_irq_hit = bus.iDEV_ADDR == ADDR_IRQ_FLAG;
    assign w_ch_idx  = bus.iDEV_ADDR[5:4];
    assign w_off     = bus.iDEV_ADDR[3:0];

    for (genvar gi = 0; gi < P_CHANNELS; gi++) begin : g_ch
        assign w_sel[gi]      = w_ch_hit && (w_ch_idx == 2'(gi));
        assign w_pop[gi]      = w_rd && w_sel[gi] && (w_off == OFF_DATA);
        assign w_ctrl_wr[gi]  = w_wr && w_sel[gi] && (w_off == OFF_CTRL);
        assign w_clr_ovf[gi]  = w_wr && w_sel[gi] && (w_off == OFF_STATUS) && bus.iDEV_DATA[ST_OVF];
        assign w_clr_ferr[gi] = w_wr && w_sel[gi] && (w_off == OFF_STATUS) && bus.iDEV_DATA[ST_FERR];
        assign w_clr_tout[gi] = w_wr && w_sel[gi] && (w_off == OFF_STATUS) && bus.iDEV_DATA[ST_TOUT];

        ps2_multi_rx_channel #(
            .P_FIFO_DEPTH   (P_FIFO_DEPTH),
            .P_FIFO_DEPTH_N (P_FIFO_DEPTH_N),
            .P_TIMEOUT      (P_TIMEOUT)
        ) u_rx (
            .i_clk       (iCLOCK),
            .i_rst       (iRESET_SYNC),
            .i_ps2_clk   (iPS2_CLOCK[gi]),
            .i_ps2_data  (iPS2_DATA[gi]),
            .i_rx_en     (r_rx_en[gi]),
            .i_pop       (w_pop[gi]),
            .o_push      (w_push[gi]),
            .o_overflow  (w_ovf_set[gi]),
            .o_frame_err (w_ferr_set[gi]),
            .o_timeout   (w_tout_set[gi]),
            .o_count     (w_count[gi]),
            .o_head      (w_head[gi])
        );
    end

    assign w_pend_set = w_push & r_irq_en;

    always_comb begin
        w_rd_data = '0;
        if (w_irq_hit) begin
            w_rd_data[P_CHANNELS-1:0] = r_pending;
        end
        for (int c = 0; c < P_CHANNELS; c++) begin
            if (w_sel[c]) begin
                case (w_off)
                    OFF_DATA: begin
                        if (w_count[c] != '0) begin
                            w_rd_data = {23'h0, 1'b1, w_head[c]};
                        end
                    end
                    OFF_STATUS: begin
                        w_rd_data[P_FIFO_DEPTH_N:0] = w_count[c];
                        w_rd_data[ST_OVF]           = r_ovf[c];
                        w_rd_data[ST_FERR]          = r_ferr[c];
                        w_rd_data[ST_TOUT]          = r_tout[c];
                    end
                    OFF_CTRL: w_rd_data[1:0] = {r_irq_en[c], r_rx_en[c]};
                    default: ;
                endcase
            end
        end
    end

    // Event sets take priority over same-cycle clears for sticky and pending bits.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_req     <= 1'b0;
            r_data    <= '0;
            r_rx_en   <= '0;
            r_irq_en  <= '0;
            r_ovf     <= '0;
            r_ferr    <= '0;
            r_tout    <= '0;
            r_pending <= '0;
        end else begin
            r_req     <= w_rd;
            r_data    <= w_rd ? w_rd_data : '0;
            r_ovf     <= (r_ovf  & ~w_clr_ovf)  | w_ovf_set;
            r_ferr    <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
            r_tout    <= (r_tout & ~w_clr_tout) | w_tout_set;
            r_pending <= (w_rd && w_irq_hit) ? w_pend_set : (r_pending | w_pend_set);
            for (int c = 0; c < P_CHANNELS; c++) begin
                if (w_ctrl_wr[c]) begin
                    r_rx_en[c]  <= bus.iDEV_DATA[0];
                    r_irq_en[c] <= bus.iDEV_DATA[1];
                end
            end
        end
    end

    assign bus.oDEV_BUSY    = bus.iDEV_BUSY;
    assign bus.oDEV_REQ     = r_req;
    assign bus.oDEV_DATA    = r_data;
    assign bus.oDEV_IRQ_REQ = (|r_pending) && !bus.iDEV_IRQ_BUSY;

endmodule

// File: doc/ps2_multi_controller.md
# ps2_multi_controller

Parametrised multi-channel PS/2 receiver that serves keyboard and mouse ports behind one bus slave. It provides a per-channel scancode FIFO, frame error detection, a frame timeout, and a shared maskable interrupt. It sits on the device data bus next to the other memory-mapped peripherals and drives one IRQ line into the interrupt controller.

## Interface
Parameters:
- P_CHANNELS, 2, number of PS/2 ports; legal range 1–4.
- P_FIFO_DEPTH, 32, entries per channel FIFO; must be a power of two.
- P_FIFO_DEPTH_N, 5, log2(P_FIFO_DEPTH).
- P_TIMEOUT, 50000, iCLOCK cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- iCLOCK  in  1  single clock for the whole block.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iDEV_REQ  in  1  bus request.
- oDEV_BUSY  out  1  equals iDEV_BUSY (combinational passthrough).
- iDEV_RW  in  1  0 = read, 1 = write.
- iDEV_ADDR  in  32  byte address.
- iDEV_DATA  in  32  write data.
- oDEV_REQ  out  1  read-response valid.
- iDEV_BUSY  in  1  downstream busy.
- oDEV_DATA  out  32  read-response data.
- oDEV_IRQ_REQ  out  1  interrupt request.
- iDEV_IRQ_BUSY  in  1  interrupt controller busy.
- iDEV_IRQ_ACK  in  1  accepted; no effect on state.
- iPS2_CLOCK  in  P_CHANNELS  PS/2 clock pins; asynchronous.
- iPS2_DATA  in  P_CHANNELS  PS/2 data pins; asynchronous.

## Operation
- Register map, channel c, base = c*0x10:
  - DATA +0x0 (R, pops): {23'h0, valid, byte}. Reading an empty FIFO returns 0 and causes no pop.
  - STATUS +0x4 (R): [P_FIFO_DEPTH_N:0] count, [16] overflow, [17] frame_err, [18] timeout.
  - STATUS +0x4 (W): writing 1 to a bit in [18:16] clears that sticky bit.
  - CTRL +0x8 (R/W): [0] rx_en, [1] irq_en. Reset value 2'b00.
- IRQ_FLAG at 0x100 (R): [P_CHANNELS-1:0] pending. A read clears exactly the bits it returned.
- Unmapped read returns 0 with oDEV_REQ asserted. Unmapped write is ignored.
- Receiver FSM per channel:
  - States: IDLE, SHIFT, PARITY, STOP. The FSM acts only on synchronised PS/2 clock falling edges.
  - IDLE: data=0 → SHIFT with bit counter cleared. data=1 → stay in IDLE.
  - SHIFT: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: the frame is good if stop=1 and odd parity holds. Return to IDLE.
- Good frame with rx_en=1:
  - FIFO not full: push the byte. If irq_en=1, set pending[c].
  - FIFO full: drop the byte and set overflow. Count is unchanged.
- Bad frame: drop the byte and set frame_err.
- rx_en=0: frames are decoded but discarded without setting flags.
- Timeout: in any non-IDLE state, P_TIMEOUT cycles with no falling edge → IDLE and set timeout.
- oDEV_IRQ_REQ = |pending && !iDEV_IRQ_BUSY.

## Timing
- Reset values: oDEV_REQ=0, oDEV_DATA=0, oDEV_IRQ_REQ=0. All FIFOs empty, FSMs in IDLE, sticky bits and pending bits cleared, CTRL=0.
- A reset asserted mid-frame discards the partial frame.
- PS/2 pins pass through a 2-flop synchroniser, then a registered edge detector.
- FIFO push happens 4 iCLOCK cycles after the stop-bit falling edge on the pin.
- Read latency is exactly 1 cycle: oDEV_REQ and oDEV_DATA are registered and held for one cycle.
- The DATA pop takes effect in the same cycle as the request. The next read returns the next entry.
- Push and pop in the same cycle: both happen and count is unchanged. Push to a full FIFO with a simultaneous pop succeeds.
- Pending set and IRQ_FLAG read clear in the same cycle: the set wins.
- Sticky set and write-1-clear in the same cycle: the set wins.
- Count width is P_FIFO_DEPTH_N+1 bits so that full reads as P_FIFO_DEPTH. Pointers wrap modulo P_FIFO_DEPTH.

## Configuration
- PS2_MULTI_PARITY_CHECK_EN defined: a parity mismatch makes the frame bad (frame_err set, byte dropped).
- PS2_MULTI_PARITY_CHECK_EN undefined: the parity bit is latched but ignored. Only stop=0 makes a frame bad.

## Structure
- Package ps2_multi_pkg holds:
  - register offsets: DATA, STATUS, CTRL, IRQ_FLAG and the 0x10 channel stride;
  - STATUS bit indices;
  - the receiver state enum;
  - the frame bit count (11).
- One sub-module, ps2_multi_rx_channel, contains the synchroniser, edge detect, FSM, timeout counter and FIFO. The top instantiates it P_CHANNELS times and owns the bus decode, CTRL, sticky bits and IRQ logic.

## Test plan
- Channel 0, rx_en=1, irq_en=1, send byte 0x1C with valid parity → push 4 cycles after stop edge; oDEV_IRQ_REQ=1; read 0x100 → 0x1; read 0x0 → 0x11C; FIFO count 0.
- Send 33 bytes to channel 1 with no reads (P_FIFO_DEPTH=32) → STATUS at 0x14 reads 0x10020; write 0x10000 → overflow clears, count stays 32.
- Frame with wrong parity → with macro: byte dropped and STATUS bit 17 set; without macro: byte pushed and no error.
- Stop after 5 data bits and idle for P_TIMEOUT cycles → timeout bit 18 set, FSM back in IDLE; the next good frame 0xF0 is received correctly.
- Push and pop on a full FIFO in the same cycle → count stays 32 and data order is preserved; read of an empty FIFO → 0x0 with oDEV_REQ=1.
- Assert iRESET_SYNC mid-frame and with FIFO count 3 → count 0, oDEV_IRQ_REQ=0; the next full frame is received correctly.
